clk_period_meter: RTL and testbench

Measures the period and high time of a slow clock or strobe, `clk_m`, that is asynchronous to the system clock `clk_i`. Both results are counts of `clk_i` cycles. The block also flags whether the measured period is within a tolerance of an expected period, and reports when `clk_m` has stopped. It is the receiving-side check for generated clocks: it sits on a divided-clock output or an external clock pin and feeds status and debug logic.

---
 rtl/clk_period_meter.sv | 192 +++++++++++++++++++
 tb/tb_clk_period_meter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// -----------------------------------------------------------------------------
// clk_period_meter
//
// Measures the period and high time of a slow clock or strobe (clk_m) that is
// asynchronous to the system clock (clk_i). Both results are expressed in
// clk_i cycles. The block also reports whether the latest period lies within
// TOL cycles of the expected period, and raises a stall flag when clk_m has
// produced no rising edge for MAXCYC cycles.
//
// Parameters
//   CLKPERIOD  : clk_i period in ns
//   MAXPERIOD  : longest measurable clk_m period in ns
//   EXP_PERIOD : expected clk_m period in ns
//   TOL        : allowed |period - expected| in clk_i cycles
//   MAXCYC     : MAXPERIOD / CLKPERIOD, counter saturation value (derived)
//   CW         : width of the cycle counter and results (derived)
//
// Ports
//   clk_i    in  1  : system clock, rising edge
//   rst_n    in  1  : asynchronous active-low reset
//   en       in  1  : measurement enable, synchronous to clk_i
//   clk_m    in  1  : measured signal, asynchronous to clk_i
//   period_o out CW : last measured period in clk_i cycles
//   high_o   out CW : last measured high time in clk_i cycles
//   valid_o  out 1  : single-cycle pulse when period_o/high_o update
//   match_o  out 1  : last period within tolerance of the expected period
//   stall_o  out 1  : no clk_m rising edge seen for MAXCYC cycles
// -----------------------------------------------------------------------------
module clk_period_meter #(
  parameter  int CLKPERIOD  = 10,
  parameter  int MAXPERIOD  = 10240,
  parameter  int EXP_PERIOD = 1020,
  parameter  int TOL        = 2,
  localparam int MAXCYC     = MAXPERIOD / CLKPERIOD,
  localparam int CW         = $clog2(MAXCYC + 1)
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clk_m,
  output logic [CW-1:0] period_o,
  output logic [CW-1:0] high_o,
  output logic          valid_o,
  output logic          match_o,
  output logic          stall_o
);

  localparam int EXPCYC = EXP_PERIOD / CLKPERIOD;

  // Constants sized to the datapath so comparisons need no width juggling.
  // The tolerance arithmetic is carried one bit wider than the counter so the
  // absolute difference can never wrap.
  localparam logic [CW-1:0] MAXCYC_V = MAXCYC[CW-1:0];
  localparam logic [CW:0]   EXPCYC_W = EXPCYC[CW:0];
  localparam logic [CW:0]   TOL_W    = TOL[CW:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  // Counter increment that sticks at MAXCYC instead of rolling over.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == MAXCYC_V) ? v : v + CW'(1);
  endfunction

  // |v - EXPCYC| <= TOL, evaluated unsigned in CW+1 bits.
  function automatic logic in_tol(input logic [CW-1:0] v);
    logic [CW:0] ext;
    logic [CW:0] diff;
    ext  = {1'b0, v};
    diff = (ext >= EXPCYC_W) ? (ext - EXPCYC_W) : (EXPCYC_W - ext);
    return (diff <= TOL_W);
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0..p2: two-flop synchronizer (s1_p0, s2_p1) plus a delay flop
  // (s3_p2) for edge detection. Runs whenever reset is released, independent
  // of en, so edge history is already valid the moment measurement starts.
  // ---------------------------------------------------------------------------
  logic s1_p0;
  logic s2_p1;
  logic s3_p2;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      s1_p0 <= 1'b0;
      s2_p1 <= 1'b0;
      s3_p2 <= 1'b0;
    end else begin
      s1_p0 <= clk_m;
      s2_p1 <= s1_p0;
      s3_p2 <= s2_p1;
    end
  end

  logic rise;
  logic fall;

  assign rise = s2_p1 & ~s3_p2;
  assign fall = ~s2_p1 & s3_p2;

  // ---------------------------------------------------------------------------
  // Measurement FSM, cycle counter, high-time capture and registered outputs.
  //
  // IDLE : en low or just raised; counter held at 0.
  // ARM  : waiting for a reference rising edge. The first rise only starts a
  //        period (the partial period before it is meaningless). Stall is
  //        flagged if the counter saturates while waiting.
  // MEAS : each rise closes a period and publishes it. If the counter
  //        saturates first, clk_m is treated as stopped and the FSM falls
  //        back to ARM so the next rise again only re-references.
  // ---------------------------------------------------------------------------
  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] hcap;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      hcap     <= '0;
      period_o <= '0;
      high_o   <= '0;
      valid_o  <= 1'b0;
      match_o  <= 1'b0;
      stall_o  <= 1'b0;
    end else begin
      valid_o <= 1'b0;

      if (!en) begin
        // Disabling discards any period in progress; the last published
        // period_o/high_o stay visible for debug.
        state   <= IDLE;
        cnt     <= '0;
        match_o <= 1'b0;
        stall_o <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state <= ARM;
            cnt   <= '0;
          end

          ARM: begin
            if (rise) begin
              state <= MEAS;
              cnt   <= CW'(1);
            end else begin
              cnt <= sat_inc(cnt);
              if (cnt == MAXCYC_V) begin
                stall_o <= 1'b1;
              end
            end
          end

          MEAS: begin
            // cnt at the falling edge equals the high time, since the
            // counter was loaded with 1 on the rise that started the period.
            if (fall) begin
              hcap <= cnt;
            end

            // A rise coinciding with saturation is still a valid period of
            // exactly MAXCYC, so the rise is checked first.
            if (rise) begin
              period_o <= cnt;
              high_o   <= hcap;
              valid_o  <= 1'b1;
              match_o  <= in_tol(cnt);
              stall_o  <= 1'b0;
              cnt      <= CW'(1);
            end else if (cnt == MAXCYC_V) begin
              stall_o <= 1'b1;
              match_o <= 1'b0;
              state   <= ARM;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end

          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
module tb_clk_period_meter;

  localparam int CLKPERIOD  = 10;
  localparam int MAXPERIOD  = 10240;
  localparam int EXP_PERIOD = 1020;
  localparam int TOL        = 2;
  localparam int MAXCYC     = MAXPERIOD / CLKPERIOD;
  localparam int EXPCYC     = EXP_PERIOD / CLKPERIOD;
  localparam int CW         = $clog2(MAXCYC + 1);

  logic          clk_i = 1'b0;
  logic          rst_n;
  logic          en;
  logic          clk_m;
  logic [CW-1:0] period_o;
  logic [CW-1:0] high_o;
  logic          valid_o;
  logic          match_o;
  logic          stall_o;

  clk_period_meter #(
    .CLKPERIOD (CLKPERIOD),
    .MAXPERIOD (MAXPERIOD),
    .EXP_PERIOD(EXP_PERIOD),
    .TOL       (TOL)
  ) dut (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .en      (en),
    .clk_m   (clk_m),
    .period_o(period_o),
    .high_o  (high_o),
    .valid_o (valid_o),
    .match_o (match_o),
    .stall_o (stall_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp   = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int n_valid = 0;
  int ph      = 0;

  // clk_m value driven on each falling clk_i edge, indexed by cycle number.
  logic hist [8];
  logic en_cur, rst_cur, en_drv, rst_drv;

  // Reference model: timestamps of clk_m edges as seen after the
  // synchronizer delay, turned into periods and high times directly.
  bit m_en, m_lock;
  int m_start, m_hcap;
  int e_period, e_high;
  bit e_valid, e_match, e_stall;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // Expected outputs after rising clk_i edge n. A clk_m edge driven on the
  // falling edge of cycle k becomes visible to the measurement at edge k+3.
  task automatic model_edge(input int n);
    int  k3, k4, c, d;
    bit  r, f;
    k3 = n - 3;
    k4 = n - 4;
    r  = hist[k3[2:0]] && !hist[k4[2:0]];
    f  = !hist[k3[2:0]] && hist[k4[2:0]];
    if (!rst_drv) begin
      m_en = 0; m_lock = 0; m_start = 0; m_hcap = 0;
      e_period = 0; e_high = 0; e_valid = 0; e_match = 0; e_stall = 0;
    end else begin
      e_valid = 0;
      if (!en_drv) begin
        m_en = 0; m_lock = 0; e_match = 0; e_stall = 0;
      end else if (!m_en) begin
        m_en = 1; m_lock = 0; m_start = n + 1;
      end else begin
        c = n - m_start;
        if (c > MAXCYC) c = MAXCYC;
        if (f && m_lock) m_hcap = c;
        if (r) begin
          if (m_lock) begin
            d = (c >= EXPCYC) ? c - EXPCYC : EXPCYC - c;
            e_valid  = 1;
            e_period = c;
            e_high   = m_hcap;
            e_match  = (d <= TOL);
            e_stall  = 0;
          end
          m_lock  = 1;
          m_start = n;
        end else if (c == MAXCYC) begin
          e_stall = 1;
          if (m_lock) begin
            e_match = 0;
            m_lock  = 0;
          end
        end
      end
    end
  endtask

  task automatic tick(input logic m);
    int k;
    @(negedge clk_i);
    cyc++;
    model_edge(cyc);
    cmp("valid",  32'(valid_o),  32'(e_valid));
    cmp("period", 32'(period_o), 32'(e_period));
    cmp("high",   32'(high_o),   32'(e_high));
    cmp("match",  32'(match_o),  32'(e_match));
    cmp("stall",  32'(stall_o),  32'(e_stall));
    if (valid_o === 1'b1) n_valid++;
    k = cyc;
    clk_m = m;
    hist[k[2:0]] = m;
    en = en_cur;
    en_drv = en_cur;
    rst_n = rst_cur;
    rst_drv = rst_cur;
  endtask

  task automatic run_cyc(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      tick(ph < hi);
      ph = (ph + 1) % (hi + lo);
    end
  endtask

  task automatic run_per(input int hi, input int lo, input int np);
    run_cyc(hi, lo, np * (hi + lo));
  endtask

  task automatic finish_per(input int hi, input int lo);
    if (ph != 0) run_cyc(hi, lo, hi + lo - ph);
  endtask

  task automatic idle_low(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  task automatic chk_last(input string tag, input int p, input int h, input int mt);
    cmp({tag, "_period"}, 32'(period_o), 32'(p));
    cmp({tag, "_high"},   32'(high_o),   32'(h));
    cmp({tag, "_match"},  32'(match_o),  32'(mt));
    cmp({tag, "_stall"},  32'(stall_o),  32'(0));
  endtask

  int base, hi, lo, np, sel, g;

  initial begin
    for (int i = 0; i < 8; i++) hist[i] = 1'b0;
    rst_n = 1'b0; rst_cur = 1'b0; rst_drv = 1'b0;
    en = 1'b1; en_cur = 1'b1; en_drv = 1'b1;
    clk_m = 1'b0;

    // Power-up reset
    idle_low(4);
    cmp("rst_valid",  32'(valid_o),  0);
    cmp("rst_period", 32'(period_o), 0);
    cmp("rst_high",   32'(high_o),   0);
    cmp("rst_stall",  32'(stall_o),  0);
    rst_cur = 1'b1;
    tick(1'b0);

    // Nominal 1020 ns, 50% duty: first rise gives no valid
    base = n_valid;
    run_per(51, 51, 6);
    cmp("nominal_valid_cnt", 32'(n_valid - base), 5);
    chk_last("nominal", 102, 51, 1);

    // Tolerance edges on both sides of EXPCYC
    run_per(52, 52, 3); chk_last("p104", 104, 52, 1);
    run_per(53, 53, 3); chk_last("p106", 106, 53, 0);
    run_per(50, 50, 3); chk_last("p100", 100, 50, 1);
    run_per(49, 50, 3); chk_last("p99",  99,  49, 0);

    // 1200 ns, 25% duty
    run_per(30, 90, 3); chk_last("p120", 120, 30, 0);

    // Period of exactly MAXCYC: rise wins over saturation
    base = n_valid;
    run_per(512, 512, 2);
    cmp("max_valid_cnt", 32'(n_valid - base), 2);
    chk_last("pmax", MAXCYC, 512, 0);

    // Stopped clock: stall exactly MAXCYC cycles after the last counted rise
    run_per(51, 51, 3);
    idle_low(925);
    cmp("stall_early", 32'(stall_o), 0);
    idle_low(1);
    cmp("stall_on", 32'(stall_o), 1);
    idle_low(100);
    cmp("stall_hold",  32'(stall_o),  1);
    cmp("stall_match", 32'(match_o),  0);
    cmp("stall_period", 32'(period_o), 102);
    base = n_valid;
    run_per(51, 51, 1);
    cmp("restart_first_rise", 32'(n_valid - base), 0);
    run_per(51, 51, 1);
    cmp("restart_second_rise", 32'(n_valid - base), 1);
    chk_last("restart", 102, 51, 1);

    // en dropped mid-period for 50 cycles
    run_cyc(51, 51, 30);
    en_cur = 1'b0;
    base = n_valid;
    run_cyc(51, 51, 50);
    cmp("dis_valid_cnt", 32'(n_valid - base), 0);
    cmp("dis_match", 32'(match_o), 0);
    cmp("dis_period_hold", 32'(period_o), 102);
    en_cur = 1'b1;
    finish_per(51, 51);
    base = n_valid;
    run_per(51, 51, 1);
    cmp("reen_first_rise", 32'(n_valid - base), 0);
    run_per(51, 51, 1);
    cmp("reen_second_rise", 32'(n_valid - base), 1);

    // Asynchronous reset mid-period, between clock edges
    run_cyc(51, 51, 20);
    @(posedge clk_i);
    #2;
    rst_n = 1'b0; rst_cur = 1'b0; rst_drv = 1'b0;
    #1;
    cmp("arst_valid",  32'(valid_o),  0);
    cmp("arst_period", 32'(period_o), 0);
    cmp("arst_high",   32'(high_o),   0);
    cmp("arst_match",  32'(match_o),  0);
    cmp("arst_stall",  32'(stall_o),  0);
    idle_low(3);
    rst_cur = 1'b1;
    tick(1'b0);
    ph = 0;
    base = n_valid;
    run_per(51, 51, 3);
    cmp("arst_valid_cnt", 32'(n_valid - base), 2);
    chk_last("arst", 102, 51, 1);

    // Randomized segments against the reference model
    for (int it = 0; it < 10; it++) begin
      hi  = $urandom_range(2, 150);
      lo  = $urandom_range(2, 150);
      np  = $urandom_range(1, 4);
      sel = $urandom_range(0, 2);
      if (sel == 1) begin
        run_cyc(hi, lo, $urandom_range(1, hi + lo - 1));
        en_cur = 1'b0;
        run_cyc(hi, lo, $urandom_range(1, 80));
        en_cur = 1'b1;
        finish_per(hi, lo);
        run_per(hi, lo, np + 1);
      end else if (sel == 2) begin
        run_per(hi, lo, np);
        g = $urandom_range(MAXCYC - 6, MAXCYC + 6) - (hi + lo);
        idle_low(g);
        run_per(hi, lo, 2);
      end else begin
        run_per(hi, lo, np + 1);
      end
    end
    idle_low(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
